wb_ctrl: RTL and testbench
==========================

# wb_ctrl

Write-back controller between the execute stage, the multi-cycle unit (divider/long-op) and the `regs` write port. It merges single-cycle EX results and long-latency results into one registered write per cycle. It tracks the one outstanding long-op destination register and raises a stall to ID on RAW/WAW hazards against it. It is the producer side of the `regs` write interface (`we`/`waddr`/`wdata`).

## Interface
- `AW`, default 5: register address width (32 registers).
- `DW`, default 32: data width.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ex_we_i` in 1: EX result valid this cycle.
- `ex_waddr_i` in AW: EX destination register.
- `ex_wdata_i` in DW: EX result.
- `lop_issue_i` in 1: ID issues a long op this cycle.
- `lop_rd_i` in AW: destination register of the issued long op.
- `lop_done_i` in 1: long-op result valid.
- `lop_waddr_i` in AW: long-op result register.
- `lop_wdata_i` in DW: long-op result data.
- `lop_ready_o` out 1: controller accepts the long-op result this cycle.
- `id_rs1_i` in AW: source register 1 of the instruction in ID.
- `id_rs2_i` in AW: source register 2 of the instruction in ID.
- `id_rd_i` in AW: destination register of the instruction in ID.
- `id_is_lop_i` in 1: the instruction in ID is a long op.
- `stall_o` out 1: hold ID/IF, insert a bubble into EX.
- `we_o` out 1: write enable to `regs`; registered.
- `waddr_o` out AW: write address to `regs`; registered.
- `wdata_o` out DW: write data to `regs`; registered.

## Operation
- **State:**
  - `pend` (1b) and `pend_rd` (AW): the single outstanding long op.
  - `buf_v` (1b), `buf_addr`, `buf_data`: a one-entry holding buffer for a long-op result that lost arbitration.
- **Issue:** `lop_issue_i` with `pend==0` sets `pend=1`, `pend_rd=lop_rd_i`.
  - Issue with `lop_rd_i==0` still sets `pend`, because completion must be tracked.
  - Issue while `pend==1` is illegal. ID never does this, because `stall_o` prevents it; the block ignores such an issue.
- **Arbitration** per cycle, priority from highest to lowest:
  1. EX write (`ex_we_i` and `ex_waddr_i!=0`).
  2. `buf_v` entry.
  3. Incoming long-op result (`lop_done_i && lop_ready_o`).
- **Losing long-op result:** an accepted result that does not win arbitration goes into the buffer.
- **`lop_ready_o`:** `= !buf_v`, combinational. A result is accepted only when `lop_done_i && lop_ready_o`.
- **Winner write:** the winner is registered into `we_o`/`waddr_o`/`wdata_o` at the clock edge. If there is no winner, `we_o=0`; `waddr_o`/`wdata_o` then hold their previous values.
- **Writes to x0:** any write with address 0, from any source, is discarded (`we_o=0`). A long-op result to x0 still clears `pend`.
- **Clearing `pend`:** `pend` clears at the edge where the long-op result reaches the output registers (direct or from the buffer), not at acceptance.
- **`stall_o` (combinational)** is asserted when any of the following holds:
  - `pend && pend_rd!=0 && (id_rs1_i==pend_rd || id_rs2_i==pend_rd || id_rd_i==pend_rd)`
  - `pend && id_is_lop_i`
  - `buf_v`
  
  `buf_v` forces EX bubbles so the buffer drains.
- **Same-cycle events:**
  - Issue and completion of the previous op in the same cycle: the clear takes effect first, then the set.
  - `lop_done_i` with `lop_waddr_i!=pend_rd`: written anyway and `pend` cleared; this is a protocol violation for verification to flag.

## Timing
- **Reset values:** `we_o=0`, `waddr_o=0`, `wdata_o=0`, `pend=0`, `pend_rd=0`, `buf_v=0`, hence `lop_ready_o=1` and `stall_o=0`.
- **Reset mid-operation:** reset drops the pending op and the buffered result with no write.
- **EX to regfile:** 1 cycle. `ex_we_i` at cycle n gives `we_o=1` during n+1, and the regfile is updated at the end of n+1.
- **Long op, no conflict:** `lop_done_i` at n gives `we_o` at n+1. `pend` is 0 from n+1, so `stall_o` drops in n+1. ID reads in n+1 are served by the `regs` same-cycle write forwarding.
- **Long op, conflict with EX at n:**
  - Buffered at n; `buf_v=1` and `stall_o=1` from n+1.
  - Written at the first edge with no EX write, at the earliest n+1, giving `we_o` at n+2.
- **Throughput:** at most one write per cycle; EX never stalls on the write port.

## Test plan
- **EX write:** after reset, `ex_we_i=1`, `ex_waddr_i=5`, `ex_wdata_i=0x1234` at cycle 1 → `we_o=1`, `waddr_o=5`, `wdata_o=0x1234` in cycle 2, and 0 elsewhere.
- **x0 filter:** `ex_we_i=1`, `ex_waddr_i=0`, data `0xFFFF_FFFF` → `we_o` stays 0.
- **RAW hazard:**
  - Issue a long op with rd=7; ID presents `rs2=7` → `stall_o=1` every cycle until completion.
  - `lop_done_i`, `lop_waddr_i=7`, data `0xABCD` at cycle k → write visible in k+1, and `stall_o=0` in k+1.
- **Conflict:**
  - Same cycle `ex_we_i` (rd=3, `0x11`) and `lop_done_i` (rd=9, `0x22`) → cycle+1 writes r3=`0x11`.
  - `lop_ready_o=0` and `stall_o=1` while buffered; the next idle-EX cycle then writes r9=`0x22`, and `pend` clears.
- **Back-to-back long op:** second long op in ID while `pend=1` → `stall_o=1`; the issue is accepted only in the cycle after the first result is written.
- **Reset mid-op:** `rst_n=0` with `pend=1` and `buf_v=1` → next cycle: all outputs 0, `lop_ready_o=1`, `stall_o=0`, and no write of the buffered data.

Source files
------------

// File: rtl/wb_ctrl.sv
// wb_ctrl: write-back controller. Merges single-cycle EX results and
// long-latency results into one registered regfile write per cycle, tracks
// the single outstanding long op and stalls ID on hazards against it.
module wb_ctrl #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ex_we_i,
   input  logic [AW-1:0] ex_waddr_i,
   input  logic [DW-1:0] ex_wdata_i,
   input  logic          lop_issue_i,
   input  logic [AW-1:0] lop_rd_i,
   input  logic          lop_done_i,
   input  logic [AW-1:0] lop_waddr_i,
   input  logic [DW-1:0] lop_wdata_i,
   output logic          lop_ready_o,
   input  logic [AW-1:0] id_rs1_i,
   input  logic [AW-1:0] id_rs2_i,
   input  logic [AW-1:0] id_rd_i,
   input  logic          id_is_lop_i,
   output logic          stall_o,
   output logic          we_o,
   output logic [AW-1:0] waddr_o,
   output logic [DW-1:0] wdata_o
);

   // Outstanding long op
   logic          r_pend;
   logic [AW-1:0] r_pend_rd;

   // Holding buffer for a long-op result that lost arbitration
   logic          r_buf_v;
   logic [AW-1:0] r_buf_addr;
   logic [DW-1:0] r_buf_data;

   // Registered write port
   logic          r_we;
   logic [AW-1:0] r_waddr;
   logic [DW-1:0] r_wdata;

   logic          w_ex_win;
   logic          w_lop_acc;
   logic          w_have;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_data;
   logic          w_lop_out;
   logic          w_buf_load;
   logic          w_we_next;
   logic          w_pend_set;
   logic          w_rd_hit;

   assign w_ex_win  = ex_we_i && (ex_waddr_i != '0);
   assign w_lop_acc = lop_done_i && !r_buf_v;

   // Fixed-priority arbitration: EX, then buffered result, then incoming result
   always_comb begin
      w_have     = 1'b0;
      w_sel_addr = r_waddr;
      w_sel_data = r_wdata;
      w_lop_out  = 1'b0;
      w_buf_load = 1'b0;
      if (w_ex_win) begin
         w_have     = 1'b1;
         w_sel_addr = ex_waddr_i;
         w_sel_data = ex_wdata_i;
         w_buf_load = w_lop_acc;
      end else if (r_buf_v) begin
         w_have     = 1'b1;
         w_sel_addr = r_buf_addr;
         w_sel_data = r_buf_data;
         w_lop_out  = 1'b1;
      end else if (w_lop_acc) begin
         w_have     = 1'b1;
         w_sel_addr = lop_waddr_i;
         w_sel_data = lop_wdata_i;
         w_lop_out  = 1'b1;
      end
   end

   // A winner addressed to x0 still retires the long op but never writes
   assign w_we_next = w_have && (w_sel_addr != '0);

   // Completion clears first, so an issue in the completing cycle is taken
   assign w_pend_set = lop_issue_i && (!r_pend || w_lop_out);

   assign w_rd_hit = (id_rs1_i == r_pend_rd) || (id_rs2_i == r_pend_rd) ||
                     (id_rd_i == r_pend_rd);

   assign stall_o     = (r_pend && (r_pend_rd != '0) && w_rd_hit) ||
                        (r_pend && id_is_lop_i) || r_buf_v;
   assign lop_ready_o = !r_buf_v;

   assign we_o    = r_we;
   assign waddr_o = r_waddr;
   assign wdata_o = r_wdata;

   // Write port register: address/data hold when nothing is written
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= w_we_next;
         if (w_we_next) begin
            r_waddr <= w_sel_addr;
            r_wdata <= w_sel_data;
         end
      end
   end

   // Pending long-op tracking
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pend    <= 1'b0;
         r_pend_rd <= '0;
      end else if (w_pend_set) begin
         r_pend    <= 1'b1;
         r_pend_rd <= lop_rd_i;
      end else if (w_lop_out) begin
         r_pend    <= 1'b0;
      end
   end

   // Holding buffer: load on lost arbitration, drain when it wins
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_buf_v    <= 1'b0;
         r_buf_addr <= '0;
         r_buf_data <= '0;
      end else if (w_buf_load) begin
         r_buf_v    <= 1'b1;
         r_buf_addr <= lop_waddr_i;
         r_buf_data <= lop_wdata_i;
      end else if (r_buf_v && !w_ex_win) begin
         r_buf_v    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: directed stimulus for wb_ctrl; expected regfile writes go into
// a scoreboard queue tagged with the cycle they must appear in, and a
// monitor on the falling edge checks every write the DUT presents.
module tb_wb_ctrl;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ex_we_i;
   logic [AW-1:0] ex_waddr_i;
   logic [DW-1:0] ex_wdata_i;
   logic          lop_issue_i;
   logic [AW-1:0] lop_rd_i;
   logic          lop_done_i;
   logic [AW-1:0] lop_waddr_i;
   logic [DW-1:0] lop_wdata_i;
   logic          lop_ready_o;
   logic [AW-1:0] id_rs1_i;
   logic [AW-1:0] id_rs2_i;
   logic [AW-1:0] id_rd_i;
   logic          id_is_lop_i;
   logic          stall_o;
   logic          we_o;
   logic [AW-1:0] waddr_o;
   logic [DW-1:0] wdata_o;

   wb_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ex_we_i     (ex_we_i),
      .ex_waddr_i  (ex_waddr_i),
      .ex_wdata_i  (ex_wdata_i),
      .lop_issue_i (lop_issue_i),
      .lop_rd_i    (lop_rd_i),
      .lop_done_i  (lop_done_i),
      .lop_waddr_i (lop_waddr_i),
      .lop_wdata_i (lop_wdata_i),
      .lop_ready_o (lop_ready_o),
      .id_rs1_i    (id_rs1_i),
      .id_rs2_i    (id_rs2_i),
      .id_rd_i     (id_rd_i),
      .id_is_lop_i (id_is_lop_i),
      .stall_o     (stall_o),
      .we_o        (we_o),
      .waddr_o     (waddr_o),
      .wdata_o     (wdata_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            c;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc  = 0;
   int   ncmp = 0;
   int   nerr = 0;

   // Cycle counter, advanced at every rising edge
   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: every we_o must match the head of the scoreboard
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].c < cyc) begin
         ncmp++;
         nerr++;
         $display("FAIL missed_write cyc=%0d: no write seen, required addr=%0d data=0x%08h in cyc %0d",
                  cyc, q[0].a, q[0].d, q[0].c);
         void'(q.pop_front());
      end
      if (we_o) begin
         ncmp++;
         if (q.size() == 0 || q[0].c != cyc) begin
            nerr++;
            $display("FAIL unexpected_write cyc=%0d: got addr=%0d data=0x%08h, required no write",
                     cyc, waddr_o, wdata_o);
         end else begin
            mon_e = q.pop_front();
            if (waddr_o !== mon_e.a || wdata_o !== mon_e.d) begin
               nerr++;
               $display("FAIL write_value cyc=%0d: got addr=%0d data=0x%08h, required addr=%0d data=0x%08h",
                        cyc, waddr_o, wdata_o, mon_e.a, mon_e.d);
            end else begin
               $display("write cyc=%0d addr=%0d data=0x%08h ok", cyc, waddr_o, wdata_o);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s cyc=%0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      e.c = cyc + 1;
      q.push_back(e);
   endtask

   // Advance to just after the next rising edge and idle all inputs
   task automatic step();
      @(posedge clk);
      #1;
      ex_we_i     = 1'b0;
      ex_waddr_i  = '0;
      ex_wdata_i  = '0;
      lop_issue_i = 1'b0;
      lop_rd_i    = '0;
      lop_done_i  = 1'b0;
      lop_waddr_i = '0;
      lop_wdata_i = '0;
      id_rs1_i    = '0;
      id_rs2_i    = '0;
      id_rd_i     = '0;
      id_is_lop_i = 1'b0;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      step();
      step();
      settle();
      chk("reset_we",    {31'd0, we_o},        32'd0);
      chk("reset_waddr", {27'd0, waddr_o},     32'd0);
      chk("reset_wdata", wdata_o,              32'd0);
      chk("reset_ready", {31'd0, lop_ready_o}, 32'd1);
      chk("reset_stall", {31'd0, stall_o},     32'd0);
      rst_n = 1'b1;

      // EX write to r5
      step();
      ex_we_i = 1'b1; ex_waddr_i = 5; ex_wdata_i = 32'h1234;
      push(5, 32'h1234);
      step();
      settle();
      chk("ex_we_visible", {31'd0, we_o}, 32'd1);
      step();
      settle();
      chk("ex_we_oneshot", {31'd0, we_o}, 32'd0);

      // EX write to x0 is dropped
      ex_we_i = 1'b1; ex_waddr_i = 0; ex_wdata_i = 32'hFFFF_FFFF;
      step();
      settle();
      chk("x0_we", {31'd0, we_o}, 32'd0);
      chk("x0_waddr_hold", {27'd0, waddr_o}, 32'd5);

      // RAW hazard against long op rd=7
      lop_issue_i = 1'b1; lop_rd_i = 7;
      settle();
      chk("issue_no_stall", {31'd0, stall_o}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         id_rs2_i = 7;
         settle();
         chk("raw_stall", {31'd0, stall_o}, 32'd1);
      end
      step();
      id_rs2_i = 7;
      lop_done_i = 1'b1; lop_waddr_i = 7; lop_wdata_i = 32'hABCD;
      settle();
      chk("raw_stall_done_cyc", {31'd0, stall_o}, 32'd1);
      chk("raw_ready", {31'd0, lop_ready_o}, 32'd1);
      push(7, 32'hABCD);
      step();
      id_rs2_i = 7;
      settle();
      chk("raw_stall_drop", {31'd0, stall_o}, 32'd0);

      // EX/long-op conflict: r3 from EX first, r9 from the buffer later
      lop_issue_i = 1'b1; lop_rd_i = 9;
      step();
      ex_we_i = 1'b1; ex_waddr_i = 3; ex_wdata_i = 32'h11;
      lop_done_i = 1'b1; lop_waddr_i = 9; lop_wdata_i = 32'h22;
      push(3, 32'h11);
      step();
      ex_we_i = 1'b1; ex_waddr_i = 4; ex_wdata_i = 32'h44;
      settle();
      chk("buf_ready_low", {31'd0, lop_ready_o}, 32'd0);
      chk("buf_stall", {31'd0, stall_o}, 32'd1);
      push(4, 32'h44);
      step();
      settle();
      chk("buf_ready_low2", {31'd0, lop_ready_o}, 32'd0);
      chk("buf_stall2", {31'd0, stall_o}, 32'd1);
      push(9, 32'h22);
      step();
      id_rs1_i = 9;
      settle();
      chk("buf_drained_ready", {31'd0, lop_ready_o}, 32'd1);
      chk("buf_drained_stall", {31'd0, stall_o}, 32'd0);

      // Back-to-back long ops
      lop_issue_i = 1'b1; lop_rd_i = 10;
      step();
      id_is_lop_i = 1'b1;
      settle();
      chk("b2b_stall", {31'd0, stall_o}, 32'd1);
      step();
      id_is_lop_i = 1'b1;
      lop_done_i = 1'b1; lop_waddr_i = 10; lop_wdata_i = 32'h33;
      settle();
      chk("b2b_stall_done", {31'd0, stall_o}, 32'd1);
      push(10, 32'h33);
      step();
      id_is_lop_i = 1'b1;
      settle();
      chk("b2b_released", {31'd0, stall_o}, 32'd0);
      lop_issue_i = 1'b1; lop_rd_i = 11;
      step();
      // An issue while pending must be ignored
      lop_issue_i = 1'b1; lop_rd_i = 12;
      id_rd_i = 11;
      settle();
      chk("b2b_second_pend", {31'd0, stall_o}, 32'd1);
      step();
      id_rd_i = 12;
      settle();
      chk("illegal_issue_ignored", {31'd0, stall_o}, 32'd0);

      // Completion and new issue in the same cycle
      lop_done_i = 1'b1; lop_waddr_i = 11; lop_wdata_i = 32'h55;
      lop_issue_i = 1'b1; lop_rd_i = 13;
      push(11, 32'h55);
      step();
      id_rd_i = 13;
      settle();
      chk("same_cyc_reissue", {31'd0, stall_o}, 32'd1);
      lop_done_i = 1'b1; lop_waddr_i = 13; lop_wdata_i = 32'h66;
      push(13, 32'h66);

      // Long op to x0: tracked, never written
      step();
      lop_issue_i = 1'b1; lop_rd_i = 0;
      step();
      settle();
      chk("x0_lop_no_rd_stall", {31'd0, stall_o}, 32'd0);
      id_is_lop_i = 1'b1;
      settle();
      chk("x0_lop_pend", {31'd0, stall_o}, 32'd1);
      lop_done_i = 1'b1; lop_waddr_i = 0; lop_wdata_i = 32'h99;
      step();
      id_is_lop_i = 1'b1;
      settle();
      chk("x0_lop_cleared", {31'd0, stall_o}, 32'd0);
      chk("x0_lop_we", {31'd0, we_o}, 32'd0);

      // Reset with a pending op and a buffered result
      lop_issue_i = 1'b1; lop_rd_i = 14;
      step();
      ex_we_i = 1'b1; ex_waddr_i = 2; ex_wdata_i = 32'h77;
      lop_done_i = 1'b1; lop_waddr_i = 14; lop_wdata_i = 32'h88;
      push(2, 32'h77);
      step();
      rst_n = 1'b0;
      settle();
      chk("pre_rst_ready", {31'd0, lop_ready_o}, 32'd0);
      chk("pre_rst_stall", {31'd0, stall_o}, 32'd1);
      step();
      id_is_lop_i = 1'b1; id_rd_i = 14;
      settle();
      chk("rst_mid_we",    {31'd0, we_o},        32'd0);
      chk("rst_mid_waddr", {27'd0, waddr_o},     32'd0);
      chk("rst_mid_wdata", wdata_o,              32'd0);
      chk("rst_mid_ready", {31'd0, lop_ready_o}, 32'd1);
      chk("rst_mid_stall", {31'd0, stall_o},     32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step();
      @(negedge clk);
      #1;

      ncmp++;
      if (q.size() != 0) begin
         nerr++;
         $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nerr);
      $finish;
   end

endmodule
